mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//  Shares the 2:1 mux datapath (sel=0 -> a, sel=1 -> b) between two requesters.
//  Round-robin FSM owns the mux sel, grants one requester at a time with a burst
//  limit, and drives a one-entry registered output stage using a valid/ready handshake.
//  Sits between two producer blocks and a single downstream consumer.
// PARAMETERS
//  WIDTH      8  data width of a, b and out_data
//  MAX_BURST  4  max consecutive accepted beats for one owner while the other requests (>=1)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  req_a      in   1      requester A has a beat on data_a
//  data_a     in   WIDTH  requester A data
//  gnt_a      out  1      A's beat accepted this cycle (combinational)
//  req_b      in   1      requester B has a beat on data_b
//  data_b     in   WIDTH  requester B data
//  gnt_b      out  1      B's beat accepted this cycle (combinational)
//  sel        out  1      registered mux select: 0 = A owns, 1 = B owns
//  out_valid  out  1      out_data holds a beat
//  out_data   out  WIDTH  registered mux output
//  out_ready  in   1      consumer takes beat when out_valid && out_ready
//  busy       out  1      FSM not in IDLE
// BEHAVIOUR
//  Reset: state=IDLE, sel=0, last=B (A wins first tie), burst_cnt=0, out_valid=0,
//   out_data=0; gnt_a/gnt_b=0. An in-flight output beat is discarded.
//  FSM states: IDLE, OWN_A, OWN_B; transitions on clk rising edge.
//   IDLE: only req_a -> OWN_A; only req_b -> OWN_B; both -> opposite of last; none -> IDLE.
//   OWN_x: stay while req_x and (burst_cnt<MAX_BURST or other not requesting).
//    req_x low: other requesting -> OWN_other, else IDLE.
//    burst_cnt==MAX_BURST and other requesting -> OWN_other.
//   On entering OWN_x: sel=(x==B), last=x, burst_cnt=0.
//  Grant: gnt_x = (state==OWN_x) && req_x && (!out_valid || out_ready). No grant in IDLE;
//   first grant is one cycle after the request is seen (arbitration cycle).
//  Accepted beat: out_data<=data_x, out_valid<=1 next edge (latency 1); burst_cnt+1, saturates.
//  Pop without new beat: out_valid<=0, out_data holds. Pop and accept in one cycle: replace, valid=1.
//  Back-pressure: out_valid && !out_ready -> no grants, out_data stable, FSM holds state.
//  Requester may drop req without a grant; no beat is lost or duplicated.
//  Throughput: 1 beat/cycle while owner streams and out_ready=1; 1 idle cycle per owner switch.
// CONFIGURATION
//  ARB_LOCK_EN defined: extra inputs lock_a, lock_b (1 bit). While owner's lock=1,
//   burst limit is ignored (no forced switch); release takes effect the next cycle.
//   lock of a non-owner has no effect.
//  ARB_LOCK_EN undefined: no lock ports; burst limit always applies.
// TESTING
//  1 Reset: rst=1 mid-stream -> all outputs 0, sel=0, busy=0 immediately (async).
//  2 Single: req_a=1, data_a=8'h3C, out_ready=1 -> gnt_a at cycle 2, out_data=3C cycle 3.
//  3 Tie: req_a=req_b=1 from reset -> A first; after 4 A beats sel=1, B gets 4, then A.
//  4 Stall: out_ready=0 with out_valid=1 -> gnt_a=gnt_b=0, out_data held 5 cycles, no loss.
//  5 Drop: owner A drops req while B requests -> OWN_B next cycle, sel=1, no extra beat.
//  6 ARB_LOCK_EN: lock_a=1, both requesting 10 beats -> all 10 to A, then B granted.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a 2:1 mux feeding a one-entry valid/ready output stage.
// Optional ARB_LOCK_EN adds lock_a/lock_b to suspend the burst limit for the owner.
module mux_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             gnt_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_b,
`ifdef ARB_LOCK_EN
    input  logic             lock_a,
    input  logic             lock_b,
`endif
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t           state_q;
    logic             sel_q;
    logic             last_b_q;
    logic [CW-1:0]    cnt_q;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    logic             own_a;
    logic             own_b;
    logic             req_own;
    logic             req_oth;
    logic             lock_own;
    logic             limit_hit;
    logic             stall;
    logic             keep;
    logic             accept;
    logic [WIDTH-1:0] mux_d;

    always_comb begin
        own_a   = (state_q == OWN_A);
        own_b   = (state_q == OWN_B);
        req_own = own_b ? req_b : req_a;
        req_oth = own_b ? req_a : req_b;
`ifdef ARB_LOCK_EN
        lock_own = own_b ? lock_b : lock_a;
`else
        lock_own = 1'b0;
`endif
        limit_hit = (cnt_q == CW'(MAX_BURST)) && req_oth && !lock_own;
        stall     = valid_q && !out_ready;
        // Owner keeps the mux only while it still qualifies to stay
        keep   = req_own && !limit_hit;
        gnt_a  = own_a && keep && !stall;
        gnt_b  = own_b && keep && !stall;
        accept = gnt_a || gnt_b;
        mux_d  = sel_q ? data_b : data_a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            last_b_q <= 1'b1;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            if (!stall) begin
                unique case (state_q)
                    IDLE: begin
                        if (req_a && (!req_b || last_b_q)) begin
                            state_q  <= OWN_A;
                            sel_q    <= 1'b0;
                            last_b_q <= 1'b0;
                            cnt_q    <= '0;
                        end else if (req_b) begin
                            state_q  <= OWN_B;
                            sel_q    <= 1'b1;
                            last_b_q <= 1'b1;
                            cnt_q    <= '0;
                        end
                    end
                    OWN_A, OWN_B: begin
                        if (!keep) begin
                            if (req_oth) begin
                                state_q  <= own_a ? OWN_B : OWN_A;
                                sel_q    <= own_a;
                                last_b_q <= own_a;
                                cnt_q    <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else if (cnt_q != CW'(MAX_BURST)) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
            if (accept) begin
                data_q  <= mux_d;
                valid_q <= 1'b1;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign sel       = sel_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: producers feed queues, monitor checks beat order.
// Lock scenario is built only when ARB_LOCK_EN is defined.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_a = 1'b0;
    logic [7:0] data_a = '0;
    logic       gnt_a;
    logic       req_b = 1'b0;
    logic [7:0] data_b = '0;
    logic       gnt_b;
`ifdef ARB_LOCK_EN
    logic       lock_a = 1'b0;
    logic       lock_b = 1'b0;
`endif
    logic       sel;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;
    logic       busy;

    mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .data_a    (data_a),
        .gnt_a     (gnt_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .gnt_b     (gnt_b),
`ifdef ARB_LOCK_EN
        .lock_a    (lock_a),
        .lock_b    (lock_b),
`endif
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    logic       s_ga, s_gb, s_sel, s_ov, s_busy;
    logic [7:0] s_od;
    int na, fgb, fgb_na, lga;
    logic fgb_sel;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_extra: got %0h expected none", out_data);
            end else begin
                chk("sb_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic drive();
        req_a  = (qa.size() != 0);
        data_a = req_a ? qa[0] : 8'h00;
        req_b  = (qb.size() != 0);
        data_b = req_b ? qb[0] : 8'h00;
    endtask

    task automatic cycle();
        @(negedge clk);
        s_ga   = gnt_a;
        s_gb   = gnt_b;
        s_sel  = sel;
        s_ov   = out_valid;
        s_od   = out_data;
        s_busy = busy;
        @(posedge clk);
        #1;
        if (s_ga) void'(qa.pop_front());
        if (s_gb) void'(qb.pop_front());
        drive();
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        qa.delete();
        qb.delete();
        exp_q.delete();
        drive();
        out_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run(input string nm);
        int n = 0;
        na = 0; fgb = -1; fgb_na = -1; lga = -1; fgb_sel = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            cycle();
            n++;
            if (s_ga) begin
                na++;
                if (fgb < 0) lga = n;
            end
            if (s_gb && fgb < 0) begin
                fgb = n; fgb_na = na; fgb_sel = s_sel;
            end
        end
        if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d queued expected 0", nm, exp_q.size());
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", {gnt_a, gnt_b}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Async reset mid-stream while B owns
        qb = '{8'h01, 8'h02, 8'h03, 8'h04};
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        drive();
        repeat (3) cycle();
        chk("mid_valid", out_valid, 1);
        chk("mid_sel", sel, 1);
        #2 rst = 1'b1;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_sel", sel, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_gnt", {gnt_a, gnt_b}, 0);
        chk("mrst_data", out_data, 0);
        exp_q.delete();
        qb.delete();
        drive();
        @(posedge clk);
        #1 rst = 1'b0;

        // Single beat latency
        do_reset();
        qa = '{8'h3C};
        exp_q = '{8'h3C};
        drive();
        cycle();
        chk("single_c1_gnt", s_ga, 0);
        chk("single_c1_busy", s_busy, 0);
        cycle();
        chk("single_c2_gnt", s_ga, 1);
        chk("single_c2_sel", s_sel, 0);
        cycle();
        chk("single_c3_valid", s_ov, 1);
        chk("single_c3_data", s_od, 8'h3C);
        run("single");

        // Tie from reset with burst limit
        do_reset();
        qa = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        qb = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1,
                  8'hB2, 8'hB3, 8'hA4, 8'hA5, 8'hB4, 8'hB5};
        drive();
        run("tie");
        chk("tie_a_first", fgb_na, 4);
        chk("tie_sel", fgb_sel, 1);
        chk("tie_gap", fgb - lga, 2);
        chk("tie_a_total", na, 6);

        // Back-pressure hold
        do_reset();
        out_ready = 1'b0;
        qa = '{8'h11, 8'h22, 8'h33};
        exp_q = '{8'h11, 8'h22, 8'h33};
        drive();
        cycle();
        cycle();
        chk("stall_first_gnt", s_ga, 1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_gnt", {s_ga, s_gb}, 0);
            chk("stall_data", {s_ov, s_od}, {1'b1, 8'h11});
        end
        out_ready = 1'b1;
        run("stall");

        // Owner drops request while other waits
        do_reset();
        qa = '{8'hC1, 8'hC2};
        qb = '{8'hD1};
        exp_q = '{8'hC1, 8'hC2, 8'hD1};
        drive();
        run("drop");
        chk("drop_a_beats", fgb_na, 2);
        chk("drop_sel", fgb_sel, 1);
        chk("drop_gap", fgb - lga, 2);

`ifdef ARB_LOCK_EN
        do_reset();
        lock_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            qa.push_back(8'h50 + 8'(i));
            exp_q.push_back(8'h50 + 8'(i));
        end
        qb = '{8'hE1, 8'hE2};
        exp_q.push_back(8'hE1);
        exp_q.push_back(8'hE2);
        drive();
        run("lock");
        chk("lock_a_beats", fgb_na, 10);
        lock_a = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
